// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared widths, default latency and FSM encoding for the
//               block data memory and its dcache-side interface.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

    localparam int c_block_addr_width = 6;
    localparam int c_block_data_width = 32;
    localparam int c_default_latency  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a down-counter that must hold LATENCY-1.
    function automatic int lat_cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_block_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_block_array
// Description : Block storage with synchronous write, registered read and
//               clear-all on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_block_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = c_block_addr_width,
    parameter int DATA_WIDTH = c_block_data_width
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // The read register only moves on a read strobe, so it holds the last block.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (i_wr_en) begin
                r_mem[i_addr] <= i_wr_data;
            end
            if (i_rd_en) begin
                r_rd_data <= r_mem[i_addr];
            end
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Fixed-latency block memory responder for dcache misses and
//               write-backs, with protocol-error flag and access counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = c_block_addr_width,
    parameter int DATA_WIDTH = c_block_data_width,
    parameter int LATENCY    = c_default_latency,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_writedata,
    output logic [DATA_WIDTH-1:0] mem_readdata,
    output logic                  mem_busywait,
    output logic                  protocol_error,
    output logic [CNT_WIDTH-1:0]  read_count,
    output logic [CNT_WIDTH-1:0]  write_count
);

    localparam int c_lat_w = lat_cnt_width(LATENCY);

    state_t                r_state;
    state_t                w_next_state;
    logic [c_lat_w-1:0]    r_lat_cnt;
    logic                  r_op_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_protocol_error;
    logic [CNT_WIDTH-1:0]  r_read_count;
    logic [CNT_WIDTH-1:0]  r_write_count;

    logic w_request;
    logic w_busywait;
    logic w_capture;
    logic w_commit;
    logic w_commit_wr;
    logic w_commit_rd;

    assign w_request = mem_read | mem_write;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busywait   = 1'b0;
        w_capture    = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                w_busywait = w_request;
                if (w_request) begin
                    w_capture    = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                w_busywait = 1'b1;
                if (r_lat_cnt == '0) begin
                    w_commit     = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                // A request still high here belongs to the finished access.
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_commit_wr = w_commit &  r_op_write;
    assign w_commit_rd = w_commit & ~r_op_write;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_lat_cnt        <= '0;
            r_op_write       <= 1'b0;
            r_addr           <= '0;
            r_wdata          <= '0;
            r_protocol_error <= 1'b0;
            r_read_count     <= '0;
            r_write_count    <= '0;
        end else begin
            if (w_capture) begin
                r_addr     <= mem_address;
                r_wdata    <= mem_writedata;
                r_op_write <= mem_write;
                r_lat_cnt  <= c_lat_w'(LATENCY - 1);
                if (mem_read && mem_write) begin
                    r_protocol_error <= 1'b1;
                end
            end else if (r_state == BUSY && r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - c_lat_w'(1);
            end
            if (w_commit_wr && r_write_count != '1) begin
                r_write_count <= r_write_count + CNT_WIDTH'(1);
            end
            if (w_commit_rd && r_read_count != '1) begin
                r_read_count <= r_read_count + CNT_WIDTH'(1);
            end
        end
    end

    dmem_block_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_block_array (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (w_commit_wr),
        .i_rd_en   (w_commit_rd),
        .i_addr    (r_addr),
        .i_wr_data (r_wdata),
        .o_rd_data (mem_readdata)
    );

    assign mem_busywait   = reset & w_busywait;
    assign protocol_error = r_protocol_error;
    assign read_count     = r_read_count;
    assign write_count    = r_write_count;

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Block-granular data memory that answers the data cache's miss and write-back requests.
- Implements the responder end of the cache-to-memory interface: mem_read/mem_write, 6-bit block address, 32-bit block data, mem_busywait.
- Latches each request and holds busywait for a fixed latency, then commits the write or presents the read block for one cycle.
- Sits between the dcache and the top level; also exposes protocol-error and access-count observability.

Parameters:
- ADDR_WIDTH, 6: block address width; depth = 2**ADDR_WIDTH blocks.
- DATA_WIDTH, 32: block width in bits.
- LATENCY, 5: BUSY cycles per access; legal range >= 1.
- CNT_WIDTH, 16: width of the saturating access counters.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_read  in  1  block read request.
- mem_write  in  1  block write request.
- mem_address  in  ADDR_WIDTH  block address.
- mem_writedata  in  DATA_WIDTH  block to write.
- mem_readdata  out  DATA_WIDTH  block read result; valid while in DONE.
- mem_busywait  out  1  high while a request is pending or in service.
- protocol_error  out  1  sticky; set when read and write are both seen high in IDLE.
- read_count  out  CNT_WIDTH  completed reads, saturating.
- write_count  out  CNT_WIDTH  completed writes, saturating.

Behaviour:
- Reset: clock and reset are one clock; reset is synchronous, active-low. Reset sampled low at a posedge sets:
  - state=IDLE, latency counter=0, mem_readdata=0, protocol_error=0, both counts=0.
  - All storage blocks cleared to 0.
  - While reset is low, mem_busywait is forced 0 and no request is captured.
- States: IDLE, BUSY, DONE.
- IDLE:
  - mem_busywait = mem_read | mem_write, combinationally, in the same cycle the request appears.
  - At a posedge with a request: latch address, writedata and op; counter <= LATENCY-1; go to BUSY.
  - Both mem_read and mem_write high: treated as a write; protocol_error <= 1.
- BUSY:
  - mem_busywait=1.
  - Inputs are ignored; the latched copies are used.
  - Counter decrements each posedge.
  - At the posedge where counter==0:
    - write: storage[addr] <= data; write_count++.
    - read: mem_readdata <= storage[addr]; read_count++.
    - Either way, go to DONE.
- DONE:
  - mem_busywait=0; mem_readdata holds the block.
  - At the next posedge, go to IDLE unconditionally.
  - A request still high in DONE is the tail of the finished transaction and is not re-captured.
- Timing: request first high in cycle 0 → mem_busywait high for cycles 0..LATENCY, low in cycle LATENCY+1 (DONE). Total occupancy is LATENCY+2 cycles.
- Back-to-back: a request high in the IDLE cycle after DONE starts a new transaction.
- mem_readdata changes only on read completion or reset; it holds its last value in IDLE and BUSY.
- Write then read of the same block: the read returns the new data; there is no forwarding hazard because accesses are serialised.
- Counters saturate at all-ones and never wrap.
- protocol_error clears only on reset.
- Reset mid-BUSY: the transaction is aborted and no write is committed. A request still held after reset release is captured as new.
- Address wraps naturally within ADDR_WIDTH; there are no out-of-range accesses.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the default LATENCY value;
  - block address/data widths shared with the dcache.
- One sub-module: dmem_block_array.
  - Synchronous write port, registered read.
  - Clear-all on reset.
  - Instantiated once; the FSM, counters and error logic stay in dmem_responder.

Test Plan:
- Release reset, read addr 0x05 → busywait high in the request cycle and the 5 BUSY cycles (6 total); DONE in cycle 6 with readdata=0x00000000; read_count=1.
- Write 0xDEADBEEF to 0x2A, then read 0x2A → readdata=0xDEADBEEF in DONE; write_count=1, read_count=1.
- Read and write both high to 0x01 with data 0x12345678 → write performed, protocol_error=1 and held; a later read of 0x01 returns 0x12345678.
- Write 0xA5A5A5A5 to 0x10 with reset pulled low at the third BUSY cycle → state IDLE, busywait 0 during reset; a later read of 0x10 returns 0x00000000 and write_count=0.
- Request held through DONE, then dropped → exactly one transaction counted. Request re-raised the cycle after DONE → second transaction with full LATENCY.
- CNT_WIDTH=4, 17 reads → read_count=0xF; it does not wrap to 0x0.
